// File: rtl/hit_storage_pkg.sv
// Shared types and defaults for the address hit storage block.
package hit_storage_pkg;

    localparam int DEF_ADDRESSBITS  = 10;
    localparam int DEF_COUNTBITS    = 16;
    localparam int DEF_NUM_CHANNELS = 2;

    typedef enum logic [1:0] {
        CLEARING,
        IDLE,
        DRAINING,
        READING
    } state_e;

    // LSB of channel ch inside the packed address bus.
    function automatic int chan_lsb(input int ch, input int abits);
        return ch * abits;
    endfunction

endpackage

// File: rtl/hit_count_ram.sv
// Simple dual-port counter RAM: one write port, one registered read port (read-first), no reset.
module hit_count_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/address_hit_storage.sv
// Per-address hit counters in block RAM fed by round-robin arbitrated channels, with clear/readout sweeps.
// Define HIT_STORAGE_SATURATE_EN to saturate counters instead of wrapping.
module address_hit_storage
    import hit_storage_pkg::*;
#(
    parameter int ADDRESSBITS  = DEF_ADDRESSBITS,
    parameter int COUNTBITS    = DEF_COUNTBITS,
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                clearMemory,
    input  logic                                readMemory,
    input  logic [NUM_CHANNELS-1:0]             newAddress,
    input  logic [NUM_CHANNELS*ADDRESSBITS-1:0] address,
    output logic [NUM_CHANNELS-1:0]             storageReady,
    output logic                                readValid,
    output logic [ADDRESSBITS-1:0]              readAddress,
    output logic [COUNTBITS-1:0]                readCount,
    output logic                                busy
);
    localparam int AW = ADDRESSBITS;
    localparam int CW = COUNTBITS;
    localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic          pend_clear_q, pend_clear_d;
    logic          rd_done_q, rd_done_d;
    logic          rp_vld_q, rp_vld_d;
    logic [AW-1:0] rp_addr_q, rp_addr_d;
    logic          read_valid_q, read_valid_d;
    logic [AW-1:0] read_addr_q, read_addr_d;
    logic [CW-1:0] read_count_q, read_count_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          s1_vld_q, s2_vld_q, s3_vld_q;
    logic [AW-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s3_addr_q;
    logic [CW-1:0] s2_cnt_q, s2_cnt_d, s3_cnt_q, cur_cnt;

    logic [NUM_CHANNELS-1:0] grant;
    logic                    grant_vld;
    logic [AW-1:0]           grant_addr;
    logic [AW-1:0]           ch_addr [NUM_CHANNELS];

    logic          ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [CW-1:0] ram_wdata, ram_rdata;

    function automatic int wrap_ch(input int ch);
        return (ch >= NUM_CHANNELS) ? ch - NUM_CHANNELS : ch;
    endfunction

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
`ifdef HIT_STORAGE_SATURATE_EN
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign ch_addr[g] = address[chan_lsb(g, AW) +: AW];
    end

    // Grants are withheld in the cycle a sweep is requested so the pipeline only drains from then on.
    always_comb begin
        grant      = '0;
        grant_vld  = 1'b0;
        grant_addr = '0;
        rr_ptr_d   = rr_ptr_q;
        if (state_q == IDLE && !clearMemory && !readMemory) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (!grant_vld && newAddress[c] && c == wrap_ch(int'(rr_ptr_q) + k)) begin
                        grant[c]   = 1'b1;
                        grant_vld  = 1'b1;
                        grant_addr = ch_addr[c];
                        rr_ptr_d   = PW'(wrap_ch(c + 1));
                    end
                end
            end
        end
    end

    // s2 is about to be written; s3 was written on the same edge the s1 read sampled the RAM.
    always_comb begin
        cur_cnt = ram_rdata;
        if (s2_vld_q && s2_addr_q == s1_addr_q)      cur_cnt = s2_cnt_q;
        else if (s3_vld_q && s3_addr_q == s1_addr_q) cur_cnt = s3_cnt_q;
        s1_addr_d = grant_addr;
        s2_cnt_d  = bump(cur_cnt);
    end

    always_comb begin
        ram_we    = s2_vld_q;
        ram_waddr = s2_addr_q;
        ram_wdata = s2_cnt_q;
        ram_raddr = grant_addr;
        if (state_q == CLEARING) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_q;
            ram_wdata = '0;
        end
        if (state_q == READING) ram_raddr = sweep_q;
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        pend_clear_d = pend_clear_q;
        rd_done_d    = rd_done_q;
        rp_vld_d     = 1'b0;
        rp_addr_d    = sweep_q;
        read_valid_d = rp_vld_q;
        read_addr_d  = rp_vld_q ? rp_addr_q : read_addr_q;
        read_count_d = rp_vld_q ? ram_rdata : read_count_q;
        case (state_q)
            CLEARING: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_ADDR) state_d = IDLE;
            end
            IDLE: begin
                if (clearMemory || readMemory) begin
                    state_d      = DRAINING;
                    pend_clear_d = clearMemory;
                end
            end
            DRAINING: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d   = pend_clear_q ? CLEARING : READING;
                    sweep_d   = '0;
                    rd_done_d = 1'b0;
                end
            end
            READING: begin
                if (!rd_done_q) begin
                    rp_vld_d = 1'b1;
                    sweep_d  = sweep_q + 1'b1;
                    if (sweep_q == LAST_ADDR) rd_done_d = 1'b1;
                end
                if (read_valid_q && read_addr_q == LAST_ADDR) state_d = IDLE;
            end
            default: state_d = CLEARING;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEARING;
            sweep_q      <= '0;
            pend_clear_q <= 1'b0;
            rd_done_q    <= 1'b0;
            rp_vld_q     <= 1'b0;
            rp_addr_q    <= '0;
            read_valid_q <= 1'b0;
            read_addr_q  <= '0;
            read_count_q <= '0;
            rr_ptr_q     <= '0;
            s1_vld_q     <= 1'b0;
            s1_addr_q    <= '0;
            s2_vld_q     <= 1'b0;
            s2_addr_q    <= '0;
            s2_cnt_q     <= '0;
            s3_vld_q     <= 1'b0;
            s3_addr_q    <= '0;
            s3_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pend_clear_q <= pend_clear_d;
            rd_done_q    <= rd_done_d;
            rp_vld_q     <= rp_vld_d;
            rp_addr_q    <= rp_addr_d;
            read_valid_q <= read_valid_d;
            read_addr_q  <= read_addr_d;
            read_count_q <= read_count_d;
            rr_ptr_q     <= rr_ptr_d;
            s1_vld_q     <= grant_vld;
            s1_addr_q    <= s1_addr_d;
            s2_vld_q     <= s1_vld_q;
            s2_addr_q    <= s1_addr_q;
            s2_cnt_q     <= s2_cnt_d;
            s3_vld_q     <= s2_vld_q;
            s3_addr_q    <= s2_addr_q;
            s3_cnt_q     <= s2_cnt_q;
        end
    end

    hit_count_ram #(.AW(AW), .DW(CW)) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign storageReady = grant;
    assign readValid    = read_valid_q;
    assign readAddress  = read_addr_q;
    assign readCount    = read_count_q;
    assign busy         = (state_q != IDLE) || s1_vld_q || s2_vld_q;
endmodule

// File: tb/tb_address_hit_storage.sv
// Scoreboard bench for address_hit_storage: random and directed hits against an array-of-counts model.
module tb_address_hit_storage;
    localparam int AB    = 4;
    localparam int CB    = 4;
    localparam int NC    = 2;
    localparam int DEPTH = 1 << AB;
    localparam int CMAX  = (1 << CB) - 1;

    typedef struct { int addr; int cnt; } rd_exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clearMemory = 1'b0;
    logic          readMemory = 1'b0;
    logic [NC-1:0] newAddress = '0;
    logic [NC*AB-1:0] address = '0;
    logic [NC-1:0] storageReady;
    logic          readValid;
    logic [AB-1:0] readAddress;
    logic [CB-1:0] readCount;
    logic          busy;

    int      n_checks = 0;
    int      n_fail = 0;
    int      model_cnt [DEPTH];
    int      model_ptr = 0;
    bit      chk_rr = 1'b0;
    rd_exp_t exp_q [$];
    rd_exp_t mon_e;
    logic [NC-1:0] mon_rdy;
    int      busy_cycles;
    bit      seen;

    address_hit_storage #(.ADDRESSBITS(AB), .COUNTBITS(CB), .NUM_CHANNELS(NC)) dut (
        .clock        (clock),
        .reset        (reset),
        .clearMemory  (clearMemory),
        .readMemory   (readMemory),
        .newAddress   (newAddress),
        .address      (address),
        .storageReady (storageReady),
        .readValid    (readValid),
        .readAddress  (readAddress),
        .readCount    (readCount),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int hit(input int v);
`ifdef HIT_STORAGE_SATURATE_EN
        return (v >= CMAX) ? CMAX : v + 1;
`else
        return (v + 1) % (CMAX + 1);
`endif
    endfunction

    task automatic model_zero();
        for (int a = 0; a < DEPTH; a++) model_cnt[a] = 0;
    endtask

    // Monitor: readout scoreboard, round-robin grant check, and hit accounting on every handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (readValid) begin
                if (exp_q.size() == 0) begin
                    check("readValid_spurious", 32'(readValid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("readAddress", 32'(readAddress), 32'(mon_e.addr));
                    check("readCount", 32'(readCount), 32'(mon_e.cnt));
                end
            end
            if (chk_rr) begin
                mon_rdy = '0;
                for (int k = 0; k < NC; k++)
                    if (mon_rdy == '0 && newAddress[(model_ptr + k) % NC]) mon_rdy[(model_ptr + k) % NC] = 1'b1;
                check("storageReady_rr", 32'(storageReady), 32'(mon_rdy));
            end
            for (int c = 0; c < NC; c++) begin
                if (newAddress[c] && storageReady[c]) begin
                    model_cnt[address[c*AB +: AB]] = hit(model_cnt[address[c*AB +: AB]]);
                    model_ptr = (c + 1) % NC;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clock);
            #1;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout with busy=%0b and %0d readouts pending, expected idle", name, busy, exp_q.size());
        end
    endtask

    task automatic request_read();
        tick();
        readMemory = 1'b1;
        for (int a = 0; a < DEPTH; a++) exp_q.push_back('{a, model_cnt[a]});
        tick();
        readMemory = 1'b0;
    endtask

    task automatic request_clear();
        tick();
        clearMemory = 1'b1;
        model_zero();
        tick();
        clearMemory = 1'b0;
    endtask

    // mode 0: ch0 fixed, 1: both fixed, 2: ch1 fixed, 3: random valids/addresses biased to 5
    task automatic traffic(input int cycles, input int mode, input int fixed_a);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk_rr = 1'b1;
            case (mode)
                0: begin newAddress = 2'b01; address[0 +: AB] = AB'(fixed_a); end
                1: begin newAddress = 2'b11; address = {AB'(fixed_a), AB'(fixed_a)}; end
                2: begin newAddress = 2'b10; address[AB +: AB] = AB'(fixed_a); end
                default: begin
                    newAddress = NC'($urandom_range(0, 3));
                    for (int c = 0; c < NC; c++)
                        address[c*AB +: AB] = ($urandom_range(0, 2) == 0) ? AB'($urandom_range(0, DEPTH - 1)) : AB'(5);
                end
            endcase
        end
        tick();
        chk_rr = 1'b0;
        newAddress = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_zero();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_storageReady", 32'(storageReady), 32'd0);
        check("rst_readValid", 32'(readValid), 32'd0);
        check("rst_readAddress", 32'(readAddress), 32'd0);
        check("rst_readCount", 32'(readCount), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            else seen = 1'b1;
        end
        check("clear_sweep_cycles", 32'(busy_cycles), 32'(DEPTH));

        request_read();
        wait_idle("readout_after_reset", 100);

        traffic(5, 0, 3);
        request_read();
        wait_idle("readout_ch0_addr3", 100);

        request_clear();
        wait_idle("clear_1", 100);
        traffic(10, 1, 7);
        request_read();
        wait_idle("readout_both_addr7", 100);

        request_clear();
        wait_idle("clear_2", 100);
        traffic(80, 3, 0);
        request_read();
        wait_idle("readout_random", 100);

        request_clear();
        wait_idle("clear_3", 100);
        traffic(20, 2, 9);
        request_read();
        wait_idle("readout_addr9_x20", 100);

        // clear and read together: clear wins; a read during the sweep is ignored
        tick();
        clearMemory = 1'b1;
        readMemory = 1'b1;
        model_zero();
        tick();
        clearMemory = 1'b0;
        readMemory = 1'b0;
        @(negedge clock);
        check("busy_after_clear_read", 32'(busy), 32'd1);
        tick();
        tick();
        readMemory = 1'b1;
        tick();
        readMemory = 1'b0;
        wait_idle("clear_read_same_cycle", 100);
        request_read();
        wait_idle("readout_after_clear_read", 100);

        // reset in the middle of a readout
        traffic(3, 0, 2);
        request_read();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (readValid && readAddress == AB'(8)) seen = 1'b1;
        end
        check("saw_readout_addr8", 32'(seen), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        model_zero();
        model_ptr = 0;
        @(negedge clock);
        check("readValid_after_reset", 32'(readValid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        newAddress = 2'b11;
        address = {AB'(1), AB'(1)};
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check("ready_low_during_clear", 32'(storageReady), 32'd0);
        end
        @(negedge clock);
        check("first_grant_after_reset", 32'(storageReady), 32'b01);
        tick();
        newAddress = '0;
        wait_idle("idle_after_reset", 100);
        request_read();
        wait_idle("readout_after_reset_abort", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
